cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter FU_COUNT, default 4: number of functional-unit requesters; legal range 2..16.
REQ-002 Parameter CDB_DEPTH, default `CDB_DEPTH: number of CDB lanes driven; legal range 1..FU_COUNT.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 n_rst  input  1  reset, asynchronous assert, active-low.
REQ-005 i_flush  input  1  pipeline flush.
REQ-006 i_fu_valid  input  [FU_COUNT]  requester i holds a result.
REQ-007 i_fu_redirect  input  [FU_COUNT] x 1  result needs a redirect.
REQ-008 i_fu_data  input  [FU_COUNT] x procyon_data_t  result data.
REQ-009 i_fu_addr  input  [FU_COUNT] x procyon_addr_t  redirect/result address.
REQ-010 i_fu_tag  input  [FU_COUNT] x procyon_tag_t  destination tag.
REQ-011 o_fu_stall  output  [FU_COUNT]  requester i was not granted this cycle.
REQ-012 o_cdb_en  output  [CDB_DEPTH]  lane k broadcast valid.
REQ-013 o_cdb_redirect  output  [CDB_DEPTH] x 1  lane k redirect.
REQ-014 o_cdb_data  output  [CDB_DEPTH] x procyon_data_t  lane k data.
REQ-015 o_cdb_addr  output  [CDB_DEPTH] x procyon_addr_t  lane k address.
REQ-016 o_cdb_tag  output  [CDB_DEPTH] x procyon_tag_t  lane k tag.

Function
REQ-017 Internal round-robin pointer ptr, width $clog2(FU_COUNT), names the highest-priority requester.
REQ-018 Grant (combinational): scan requesters ptr, ptr+1, ... modulo FU_COUNT. The first CDB_DEPTH requesters with i_fu_valid set are granted. The k-th granted requester in scan order maps to lane k.
REQ-019 o_fu_stall[i] = i_fu_valid[i] AND NOT grant[i], same cycle. A stalled requester holds its valid and payload unchanged until granted.
REQ-020 Outputs are registered with 1-cycle latency. At each edge, lane k with a grant loads en=1 plus that requester's redirect/data/addr/tag.
REQ-021 At each edge, lane k with no grant loads en=0 and holds its previous payload.
REQ-022 Lanes are filled contiguously from lane 0; a lane with en=1 never sits above a lane with en=0 in the same cycle.
REQ-023 Pointer update: if any grant, ptr <= (index of last granted requester in scan order + 1) mod FU_COUNT; otherwise ptr is unchanged.
REQ-024 Fairness: a continuously valid requester is granted within ceil(FU_COUNT/CDB_DEPTH) cycles.
REQ-025 While i_flush=1: no grants, all o_fu_stall=0, all o_cdb_en cleared at the next edge, ptr unchanged, payloads held.
REQ-026 i_flush and a full request set in the same cycle: flush wins, and nothing is broadcast in the following cycle.
REQ-027 Fewer valid requesters than lanes: all valid requesters are granted, none stall, and the unused upper lanes have en=0.
REQ-028 No valid requesters: all o_cdb_en=0 next cycle and ptr unchanged.
REQ-029 Each granted requester appears on exactly one lane; no requester is ever broadcast twice from one request cycle.

Reset
REQ-030 n_rst=0 asynchronously forces o_cdb_en=0, o_cdb_redirect=0, data/addr/tag=0, ptr=0. This applies at any time, including mid-broadcast.
REQ-031 o_fu_stall is combinational; during reset it follows i_fu_valid with no grants, and requesters ignore it while n_rst=0.
REQ-032 First grant after reset release starts scanning at requester 0.

Verification (FU_COUNT=4, CDB_DEPTH=2)
REQ-033 ptr=0, FU0..FU3 all valid with tags 1..4 -> stall=4'b1100; next cycle lanes carry tags 1,2 with en=2'b11; ptr=2; following cycle lanes carry tags 3,4.
REQ-034 ptr=0, only FU3 valid (tag 7) -> stall=0; next cycle lane0 tag 7 en=1, lane1 en=0; ptr=0.
REQ-035 ptr=3, FU0, FU1, FU3 valid -> grant FU3 to lane0 and FU0 to lane1, FU1 stalled; ptr=1.
REQ-036 All valid with i_flush=1 -> stall=0; next cycle o_cdb_en=2'b00; ptr unchanged.
REQ-037 n_rst pulsed low while o_cdb_en=2'b11 -> o_cdb_en=0 immediately, before the next edge; after release, all-valid request grants FU0,FU1.
REQ-038 Random valid pattern over 10k cycles, checked by scoreboard -> every valid result broadcast exactly once and in order per requester, no lane gaps, wait time never more than 2 cycles.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: grants up to CDB_DEPTH functional-unit
// results per cycle and broadcasts them on registered, contiguously filled lanes.
`ifndef CDB_DEPTH
`define CDB_DEPTH 2
`endif

module cdb_arbiter #(
    parameter int FU_COUNT  = 4,
    parameter int CDB_DEPTH = `CDB_DEPTH,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int TAG_W     = 6
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             i_flush,
    input  logic [FU_COUNT-1:0]              i_fu_valid,
    input  logic [FU_COUNT-1:0]              i_fu_redirect,
    input  logic [FU_COUNT-1:0][DATA_W-1:0]  i_fu_data,
    input  logic [FU_COUNT-1:0][ADDR_W-1:0]  i_fu_addr,
    input  logic [FU_COUNT-1:0][TAG_W-1:0]   i_fu_tag,
    output logic [FU_COUNT-1:0]              o_fu_stall,
    output logic [CDB_DEPTH-1:0]             o_cdb_en,
    output logic [CDB_DEPTH-1:0]             o_cdb_redirect,
    output logic [CDB_DEPTH-1:0][DATA_W-1:0] o_cdb_data,
    output logic [CDB_DEPTH-1:0][ADDR_W-1:0] o_cdb_addr,
    output logic [CDB_DEPTH-1:0][TAG_W-1:0]  o_cdb_tag
);

    localparam int PTR_W = $clog2(FU_COUNT);
    localparam int CNT_W = $clog2(CDB_DEPTH + 1);

    logic [PTR_W-1:0]                  ptr_q, ptr_d;
    logic [CDB_DEPTH-1:0]              en_q, en_d;
    logic [CDB_DEPTH-1:0]              redirect_q, redirect_d;
    logic [CDB_DEPTH-1:0][DATA_W-1:0]  data_q, data_d;
    logic [CDB_DEPTH-1:0][ADDR_W-1:0]  addr_q, addr_d;
    logic [CDB_DEPTH-1:0][TAG_W-1:0]   tag_q, tag_d;

    logic [FU_COUNT-1:0]               grant;
    logic [CDB_DEPTH-1:0]              lane_vld;
    logic [CDB_DEPTH-1:0][PTR_W-1:0]   lane_src;
    logic [CNT_W-1:0]                  grant_cnt;
    logic [PTR_W:0]                    scan_idx;
    logic [PTR_W:0]                    next_ptr;
    logic [PTR_W-1:0]                  last_idx;

    // Scan from ptr with wrap; the k-th valid requester found drives lane k.
    always_comb begin
        grant     = '0;
        lane_vld  = '0;
        lane_src  = '0;
        grant_cnt = '0;
        last_idx  = ptr_q;
        scan_idx  = '0;
        for (int s = 0; s < FU_COUNT; s++) begin
            scan_idx = {1'b0, ptr_q} + (PTR_W+1)'(s);
            if (scan_idx >= (PTR_W+1)'(FU_COUNT)) begin
                scan_idx = scan_idx - (PTR_W+1)'(FU_COUNT);
            end
            if (n_rst && !i_flush && i_fu_valid[scan_idx[PTR_W-1:0]] &&
                (grant_cnt < CNT_W'(CDB_DEPTH))) begin
                grant[scan_idx[PTR_W-1:0]] = 1'b1;
                for (int k = 0; k < CDB_DEPTH; k++) begin
                    if (grant_cnt == CNT_W'(k)) begin
                        lane_vld[k] = 1'b1;
                        lane_src[k] = scan_idx[PTR_W-1:0];
                    end
                end
                grant_cnt = grant_cnt + CNT_W'(1);
                last_idx  = scan_idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        next_ptr = {1'b0, last_idx} + (PTR_W+1)'(1);
        if (next_ptr >= (PTR_W+1)'(FU_COUNT)) begin
            next_ptr = next_ptr - (PTR_W+1)'(FU_COUNT);
        end
        ptr_d = (grant_cnt != '0) ? next_ptr[PTR_W-1:0] : ptr_q;
    end

    // Idle lanes drop en but keep their last payload.
    always_comb begin
        en_d       = lane_vld;
        redirect_d = redirect_q;
        data_d     = data_q;
        addr_d     = addr_q;
        tag_d      = tag_q;
        for (int k = 0; k < CDB_DEPTH; k++) begin
            if (lane_vld[k]) begin
                redirect_d[k] = i_fu_redirect[lane_src[k]];
                data_d[k]     = i_fu_data[lane_src[k]];
                addr_d[k]     = i_fu_addr[lane_src[k]];
                tag_d[k]      = i_fu_tag[lane_src[k]];
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q      <= '0;
            en_q       <= '0;
            redirect_q <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            tag_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            en_q       <= en_d;
            redirect_q <= redirect_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            tag_q      <= tag_d;
        end
    end

    assign o_fu_stall     = i_flush ? '0 : (i_fu_valid & ~grant);
    assign o_cdb_en       = en_q;
    assign o_cdb_redirect = redirect_q;
    assign o_cdb_data     = data_q;
    assign o_cdb_addr     = addr_q;
    assign o_cdb_tag      = tag_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (FU_COUNT=4, CDB_DEPTH=2): directed
// scenarios followed by a randomized run checked against a result scoreboard.
module tb_cdb_arbiter;

    localparam int FU = 4;
    localparam int LN = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TW = 6;
    localparam int N_RAND = 10000;

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    logic flush = 1'b0;
    logic [FU-1:0]         fu_valid = '0;
    logic [FU-1:0]         fu_redirect = '0;
    logic [FU-1:0][DW-1:0] fu_data = '0;
    logic [FU-1:0][AW-1:0] fu_addr = '0;
    logic [FU-1:0][TW-1:0] fu_tag = '0;
    logic [FU-1:0]         fu_stall;
    logic [LN-1:0]         cdb_en;
    logic [LN-1:0]         cdb_redirect;
    logic [LN-1:0][DW-1:0] cdb_data;
    logic [LN-1:0][AW-1:0] cdb_addr;
    logic [LN-1:0][TW-1:0] cdb_tag;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [1:0]    fu;
        logic          redirect;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic [TW-1:0] tag;
    } item_t;

    item_t sb[$];

    cdb_arbiter #(
        .FU_COUNT(FU), .CDB_DEPTH(LN), .DATA_W(DW), .ADDR_W(AW), .TAG_W(TW)
    ) dut (
        .clk(clk), .n_rst(n_rst), .i_flush(flush),
        .i_fu_valid(fu_valid), .i_fu_redirect(fu_redirect), .i_fu_data(fu_data),
        .i_fu_addr(fu_addr), .i_fu_tag(fu_tag), .o_fu_stall(fu_stall),
        .o_cdb_en(cdb_en), .o_cdb_redirect(cdb_redirect), .o_cdb_data(cdb_data),
        .o_cdb_addr(cdb_addr), .o_cdb_tag(cdb_tag)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int i, input logic v, input logic [TW-1:0] tag);
        fu_valid[i]    = v;
        fu_tag[i]      = tag;
        fu_data[i]     = 32'hD000_0000 | 32'(tag);
        fu_addr[i]     = 32'hA000_0000 | 32'(tag);
        fu_redirect[i] = tag[0];
    endtask

    task automatic test_reset;
        #1 n_rst = 1'b0;
        set_fu(1, 1'b1, 6'd1);
        set_fu(3, 1'b1, 6'd3);
        #2;
        n_checks++; if (cdb_en !== 2'b00) begin n_fail++; $display("FAIL reset_en: got %b want 00", cdb_en); end
        n_checks++; if (cdb_tag !== '0 || cdb_data !== '0 || cdb_addr !== '0 || cdb_redirect !== '0) begin
            n_fail++; $display("FAIL reset_payload: tag %h data %h want all zero", cdb_tag, cdb_data); end
        n_checks++; if (dut.ptr_q !== 2'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d want 0", dut.ptr_q); end
        n_checks++; if (fu_stall !== 4'b1010) begin n_fail++; $display("FAIL reset_stall: got %b want 1010", fu_stall); end
        fu_valid = '0;
        #6 n_rst = 1'b1;
        tick();
        n_checks++; if (cdb_en !== 2'b00) begin n_fail++; $display("FAIL idle_en: got %b want 00", cdb_en); end
    endtask

    task automatic test_all_valid;
        for (int i = 0; i < FU; i++) set_fu(i, 1'b1, TW'(i + 1));
        #1;
        n_checks++; if (fu_stall !== 4'b1100) begin n_fail++; $display("FAIL all_stall: got %b want 1100", fu_stall); end
        tick();
        n_checks++; if (cdb_en !== 2'b11) begin n_fail++; $display("FAIL all_en1: got %b want 11", cdb_en); end
        n_checks++; if (cdb_tag[0] !== 6'd1 || cdb_tag[1] !== 6'd2) begin
            n_fail++; $display("FAIL all_tags1: got %0d,%0d want 1,2", cdb_tag[0], cdb_tag[1]); end
        n_checks++; if (cdb_data[1] !== 32'hD000_0002) begin n_fail++; $display("FAIL all_data1: got %h want d0000002", cdb_data[1]); end
        n_checks++; if (dut.ptr_q !== 2'd2) begin n_fail++; $display("FAIL all_ptr1: got %0d want 2", dut.ptr_q); end
        fu_valid[0] = 1'b0;
        fu_valid[1] = 1'b0;
        #1;
        n_checks++; if (fu_stall !== 4'b0000) begin n_fail++; $display("FAIL all_stall2: got %b want 0000", fu_stall); end
        tick();
        n_checks++; if (cdb_en !== 2'b11 || cdb_tag[0] !== 6'd3 || cdb_tag[1] !== 6'd4) begin
            n_fail++; $display("FAIL all_tags2: en %b tags %0d,%0d want 11 3,4", cdb_en, cdb_tag[0], cdb_tag[1]); end
        n_checks++; if (cdb_redirect !== 2'b01) begin n_fail++; $display("FAIL all_redirect: got %b want 01", cdb_redirect); end
        n_checks++; if (dut.ptr_q !== 2'd0) begin n_fail++; $display("FAIL all_ptr2: got %0d want 0", dut.ptr_q); end
        fu_valid = '0;
        tick();
        n_checks++; if (cdb_en !== 2'b00 || dut.ptr_q !== 2'd0) begin
            n_fail++; $display("FAIL none_valid: en %b ptr %0d want 00 0", cdb_en, dut.ptr_q); end
        n_checks++; if (cdb_tag[0] !== 6'd3 || cdb_tag[1] !== 6'd4) begin
            n_fail++; $display("FAIL none_hold: tags %0d,%0d want 3,4", cdb_tag[0], cdb_tag[1]); end
    endtask

    task automatic test_single;
        set_fu(3, 1'b1, 6'd7);
        #1;
        n_checks++; if (fu_stall !== 4'b0000) begin n_fail++; $display("FAIL single_stall: got %b want 0000", fu_stall); end
        tick();
        n_checks++; if (cdb_en !== 2'b01 || cdb_tag[0] !== 6'd7) begin
            n_fail++; $display("FAIL single_lane: en %b tag %0d want 01 7", cdb_en, cdb_tag[0]); end
        n_checks++; if (cdb_addr[0] !== 32'hA000_0007 || cdb_redirect[0] !== 1'b1) begin
            n_fail++; $display("FAIL single_payload: addr %h redir %b want a0000007 1", cdb_addr[0], cdb_redirect[0]); end
        n_checks++; if (cdb_tag[1] !== 6'd4) begin n_fail++; $display("FAIL single_hold: got %0d want 4", cdb_tag[1]); end
        n_checks++; if (dut.ptr_q !== 2'd0) begin n_fail++; $display("FAIL single_ptr: got %0d want 0", dut.ptr_q); end
        fu_valid = '0;
    endtask

    task automatic test_wrap;
        set_fu(2, 1'b1, 6'd5);
        tick();
        n_checks++; if (dut.ptr_q !== 2'd3 || cdb_tag[0] !== 6'd5) begin
            n_fail++; $display("FAIL wrap_setup: ptr %0d tag %0d want 3 5", dut.ptr_q, cdb_tag[0]); end
        fu_valid = '0;
        set_fu(0, 1'b1, 6'd8);
        set_fu(1, 1'b1, 6'd9);
        set_fu(3, 1'b1, 6'd10);
        #1;
        n_checks++; if (fu_stall !== 4'b0010) begin n_fail++; $display("FAIL wrap_stall: got %b want 0010", fu_stall); end
        tick();
        n_checks++; if (cdb_en !== 2'b11 || cdb_tag[0] !== 6'd10 || cdb_tag[1] !== 6'd8) begin
            n_fail++; $display("FAIL wrap_lanes: en %b tags %0d,%0d want 11 10,8", cdb_en, cdb_tag[0], cdb_tag[1]); end
        n_checks++; if (dut.ptr_q !== 2'd1) begin n_fail++; $display("FAIL wrap_ptr: got %0d want 1", dut.ptr_q); end
        fu_valid[0] = 1'b0;
        fu_valid[3] = 1'b0;
        tick();
        n_checks++; if (cdb_en !== 2'b01 || cdb_tag[0] !== 6'd9 || cdb_tag[1] !== 6'd8 || dut.ptr_q !== 2'd2) begin
            n_fail++; $display("FAIL wrap_tail: en %b tags %0d,%0d ptr %0d want 01 9,8 2", cdb_en, cdb_tag[0], cdb_tag[1], dut.ptr_q); end
        fu_valid = '0;
    endtask

    task automatic test_flush;
        for (int i = 0; i < FU; i++) set_fu(i, 1'b1, TW'(i + 11));
        flush = 1'b1;
        #1;
        n_checks++; if (fu_stall !== 4'b0000) begin n_fail++; $display("FAIL flush_stall: got %b want 0000", fu_stall); end
        tick();
        n_checks++; if (cdb_en !== 2'b00) begin n_fail++; $display("FAIL flush_en: got %b want 00", cdb_en); end
        n_checks++; if (dut.ptr_q !== 2'd2 || cdb_tag[0] !== 6'd9) begin
            n_fail++; $display("FAIL flush_hold: ptr %0d tag %0d want 2 9", dut.ptr_q, cdb_tag[0]); end
        flush = 1'b0;
        #1;
        n_checks++; if (fu_stall !== 4'b0011) begin n_fail++; $display("FAIL postflush_stall: got %b want 0011", fu_stall); end
        tick();
        n_checks++; if (cdb_en !== 2'b11 || cdb_tag[0] !== 6'd13 || cdb_tag[1] !== 6'd14 || dut.ptr_q !== 2'd0) begin
            n_fail++; $display("FAIL postflush_lanes: en %b tags %0d,%0d ptr %0d want 11 13,14 0", cdb_en, cdb_tag[0], cdb_tag[1], dut.ptr_q); end
        fu_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < FU; i++) set_fu(i, 1'b1, TW'(i + 1));
        tick();
        tick();
        n_checks++; if (cdb_en !== 2'b11) begin n_fail++; $display("FAIL midrst_pre: got %b want 11", cdb_en); end
        #2 n_rst = 1'b0;
        #1;
        n_checks++; if (cdb_en !== 2'b00 || cdb_tag !== '0 || cdb_data !== '0) begin
            n_fail++; $display("FAIL midrst_clear: en %b tag %h want 00 0", cdb_en, cdb_tag); end
        n_checks++; if (dut.ptr_q !== 2'd0) begin n_fail++; $display("FAIL midrst_ptr: got %0d want 0", dut.ptr_q); end
        n_checks++; if (fu_stall !== 4'b1111) begin n_fail++; $display("FAIL midrst_stall: got %b want 1111", fu_stall); end
        #2 n_rst = 1'b1;
        #1;
        n_checks++; if (fu_stall !== 4'b1100) begin n_fail++; $display("FAIL midrst_rel_stall: got %b want 1100", fu_stall); end
        tick();
        n_checks++; if (cdb_en !== 2'b11 || cdb_tag[0] !== 6'd1 || cdb_tag[1] !== 6'd2) begin
            n_fail++; $display("FAIL midrst_first: en %b tags %0d,%0d want 11 1,2", cdb_en, cdb_tag[0], cdb_tag[1]); end
        fu_valid = '0;
        tick();
    endtask

    task automatic test_random;
        logic [FU-1:0] granted;
        int stall_run[FU];
        int seq;
        int exp_cnt;
        int idx;
        item_t it;
        item_t obs;
        granted = '0;
        seq = 0;
        for (int i = 0; i < FU; i++) stall_run[i] = 0;
        for (int c = 0; c < N_RAND + 6; c++) begin
            for (int i = 0; i < FU; i++) begin
                if (!fu_valid[i] || granted[i]) begin
                    if (c < N_RAND && $urandom_range(0, 99) < 55) begin
                        it.fu       = 2'(i);
                        it.redirect = 1'($urandom_range(0, 1));
                        it.data     = {4'(i), 28'(seq)};
                        it.addr     = $urandom;
                        it.tag      = TW'($urandom_range(0, 63));
                        seq++;
                        sb.push_back(it);
                        fu_valid[i]    = 1'b1;
                        fu_redirect[i] = it.redirect;
                        fu_data[i]     = it.data;
                        fu_addr[i]     = it.addr;
                        fu_tag[i]      = it.tag;
                    end else begin
                        fu_valid[i] = 1'b0;
                    end
                end
            end
            @(negedge clk);
            granted = fu_valid & ~fu_stall;
            exp_cnt = ($countones(fu_valid) < LN) ? $countones(fu_valid) : LN;
            n_checks++; if ($countones(granted) != exp_cnt || (fu_stall & ~fu_valid) != '0) begin
                n_fail++; $display("FAIL rand_grant c%0d: valid %b stall %b want %0d grants", c, fu_valid, fu_stall, exp_cnt); end
            for (int i = 0; i < FU; i++) begin
                if (fu_valid[i] && fu_stall[i]) stall_run[i]++;
                else stall_run[i] = 0;
            end
            for (int i = 0; i < FU; i++) begin
                if (fu_valid[i]) begin
                    n_checks++; if (stall_run[i] > 1) begin
                        n_fail++; $display("FAIL rand_wait c%0d fu%0d: stalled %0d cycles want <=1", c, i, stall_run[i]); end
                end
            end
            @(posedge clk);
            #1;
            n_checks++; if (cdb_en == 2'b10 || $countones(cdb_en) != $countones(granted)) begin
                n_fail++; $display("FAIL rand_lanes c%0d: en %b want %0d contiguous lanes", c, cdb_en, $countones(granted)); end
            for (int k = 0; k < LN; k++) begin
                if (cdb_en[k]) begin
                    obs.fu = cdb_data[k][29:28];
                    obs.redirect = cdb_redirect[k];
                    obs.data = cdb_data[k];
                    obs.addr = cdb_addr[k];
                    obs.tag = cdb_tag[k];
                    idx = -1;
                    for (int j = 0; j < sb.size(); j++) begin
                        if (idx < 0 && sb[j].fu == obs.fu) idx = j;
                    end
                    n_checks++;
                    if (idx < 0) begin
                        n_fail++; $display("FAIL rand_extra c%0d lane%0d: data %h with nothing expected", c, k, obs.data);
                    end else begin
                        if (sb[idx] !== obs) begin
                            n_fail++; $display("FAIL rand_item c%0d lane%0d: got %h want %h", c, k, obs, sb[idx]);
                        end
                        sb.delete(idx);
                    end
                end
            end
        end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL rand_drain: %0d results never broadcast, want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_all_valid();
        test_single();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
